// File: rtl/rectangle_pkg.sv
// Shared RECTANGLE key-schedule definitions: S-box, round-constant LFSR, mode and FSM encodings.
// Optional 80-bit key mode is controlled by RECTANGLE_KEY80_EN in the modules that import this package.
package rectangle_pkg;

  localparam int         NR_DEFAULT = 25;
  localparam logic [4:0] RC_SEED    = 5'h01;

  typedef enum logic {
    KEY80  = 1'b0,
    KEY128 = 1'b1
  } key_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [4:0] rc_step(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage

// File: rtl/rectangle_ks_round.sv
// One combinational RECTANGLE key-schedule round: next key state plus the round key of the current state.
// mode=1 selects 128-bit; the 80-bit path exists only when RECTANGLE_KEY80_EN is defined.
module rectangle_ks_round
  import rectangle_pkg::*;
(
  input  logic [127:0] st,
  input  logic         mode,
  input  logic [4:0]   rc,
  output logic [127:0] st_next,
  output logic [63:0]  rk
);

  logic [31:0]  r [4];
  logic [31:0]  s [4];
  logic [3:0]   col;
  logic [127:0] next128;
  logic [63:0]  rk128;

  // Column c is the nibble {row3[c],row2[c],row1[c],row0[c]}; only the low 8 columns are substituted.
  always_comb begin
    col = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = st[32*i +: 32];
      s[i] = r[i];
    end
    for (int c = 0; c < 8; c++) begin
      col = sbox({r[3][c], r[2][c], r[1][c], r[0][c]});
      for (int j = 0; j < 4; j++) s[j][c] = col[j];
    end
    next128[31:0]   = {s[0][23:0], s[0][31:24]} ^ s[1] ^ {27'd0, rc};
    next128[63:32]  = s[2];
    next128[95:64]  = {s[2][15:0], s[2][31:16]} ^ s[3];
    next128[127:96] = s[0];
  end

  assign rk128 = {st[111:96], st[79:64], st[47:32], st[15:0]};

`ifdef RECTANGLE_KEY80_EN
  logic [15:0]  q [5];
  logic [15:0]  t [5];
  logic [3:0]   col80;
  logic [127:0] next80;

  always_comb begin
    col80 = '0;
    for (int i = 0; i < 5; i++) begin
      q[i] = st[16*i +: 16];
      t[i] = q[i];
    end
    for (int c = 0; c < 4; c++) begin
      col80 = sbox({q[3][c], q[2][c], q[1][c], q[0][c]});
      for (int j = 0; j < 4; j++) t[j][c] = col80[j];
    end
    next80 = {48'd0,
              t[0],
              {t[3][3:0], t[3][15:4]} ^ t[4],
              t[3],
              t[2],
              {t[0][7:0], t[0][15:8]} ^ t[1] ^ {11'd0, rc}};
  end

  assign st_next = mode ? next128 : next80;
  assign rk      = mode ? rk128 : st[63:0];
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign st_next     = next128;
  assign rk          = rk128;
`endif

endmodule

// File: rtl/rectangle_skeygen_param.sv
// RECTANGLE key-schedule engine: on start flushes the key RAM, then writes K0..K(NR) one per cycle; done pulses after.
// start is ignored while busy/done; 80-bit key mode is built only when RECTANGLE_KEY80_EN is defined.
module rectangle_skeygen_param
  import rectangle_pkg::*;
#(
  parameter int NR     = NR_DEFAULT,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              start,
  input  logic              key_mode,
  input  logic [127:0]      key,
  output logic              busy,
  output logic              done,
  output logic              flush,
  output logic              WE,
  output logic [ADDR_W-1:0] WAddr,
  output logic [63:0]       KeyIn
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NR);

  fsm_state_e        st_q;
  key_mode_e         mode_q;
  key_mode_e         start_mode;
  logic [127:0]      ks_q;
  logic [127:0]      ks_next;
  logic [127:0]      load_key;
  logic [63:0]       rk;
  logic [4:0]        rc_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;

`ifdef RECTANGLE_KEY80_EN
  assign start_mode = key_mode ? KEY128 : KEY80;
  assign load_key   = key_mode ? key : {48'd0, key[79:0]};
`else
  logic unused_key_mode;
  assign unused_key_mode = key_mode;
  assign start_mode      = KEY128;
  assign load_key        = key;
`endif

  rectangle_ks_round u_round (
    .st      (ks_q),
    .mode    (mode_q == KEY128),
    .rc      (rc_q),
    .st_next (ks_next),
    .rk      (rk)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      st_q   <= ST_IDLE;
      mode_q <= KEY80;
      ks_q   <= '0;
      rc_q   <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            ks_q   <= load_key;
            mode_q <= start_mode;
            rc_q   <= RC_SEED;
            cnt_q  <= '0;
            we_q   <= 1'b1;
            busy_q <= 1'b1;
            st_q   <= ST_GEN;
          end
        end
        ST_GEN: begin
          ks_q <= ks_next;
          rc_q <= rc_step(rc_q);
          // Counter returns to 0 on exit so WAddr idles at zero.
          if (cnt_q == LAST) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          st_q   <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign flush = start & (st_q == ST_IDLE);
  assign busy  = busy_q;
  assign done  = done_q;
  assign WE    = we_q;
  assign WAddr = cnt_q;
  assign KeyIn = we_q ? rk : 64'd0;

endmodule

// File: tb/tb_rectangle_skeygen_param.sv
// Directed bench for rectangle_skeygen_param: default build (NR=25) plus an NR=11/ADDR_W=4 instance.
// 80-bit expectations follow RECTANGLE_KEY80_EN so the same bench fits either build.
module tb_rectangle_skeygen_param;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         start = 1'b0;
  logic         start11 = 1'b0;
  logic         key_mode = 1'b0;
  logic [127:0] key = '0;

  logic         busy, done, flush, WE;
  logic [4:0]   WAddr;
  logic [63:0]  KeyIn;
  logic         busy11, done11, flush11, WE11;
  logic [3:0]   WAddr11;
  logic [63:0]  KeyIn11;

  rectangle_skeygen_param dut (
    .Clk(Clk), .RstN(RstN), .start(start), .key_mode(key_mode), .key(key),
    .busy(busy), .done(done), .flush(flush), .WE(WE), .WAddr(WAddr), .KeyIn(KeyIn)
  );

  rectangle_skeygen_param #(.NR(11), .ADDR_W(4)) dut11 (
    .Clk(Clk), .RstN(RstN), .start(start11), .key_mode(key_mode), .key(key),
    .busy(busy11), .done(done11), .flush(flush11), .WE(WE11), .WAddr(WAddr11), .KeyIn(KeyIn11)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] KEYA    = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [63:0]  K1_128  = 64'h0000_0000_00FF_00FE;
  localparam logic [63:0]  K2_128  = 64'h0000_0000_0001_00FC;
  localparam logic [63:0]  K0A_128 = 64'h2233_6677_AABB_EEFF;
`ifdef RECTANGLE_KEY80_EN
  localparam logic [63:0]  K1_80   = 64'h0000_0000_000F_000E;
  localparam logic [63:0]  K0A_80  = 64'h8899_AABB_CCDD_EEFF;
`else
  localparam logic [63:0]  K1_80   = K1_128;
  localparam logic [63:0]  K0A_80  = K0A_128;
`endif

  logic [4:0] rc_exp [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C,
                              5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11,
                              5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D};

  int n_checks = 0;
  int n_fail = 0;

  int          cap_n, done_cyc, done_cnt, flush_cnt, busy_mis;
  logic        flush_t;
  logic [7:0]  cap_addr [64];
  logic [63:0] cap_dat  [64];
  logic [4:0]  rc_log   [64];

  // Raise start for one cycle with the given mode/key; leaves the bench at the negedge of cycle T+1.
  task automatic pulse_start(input bit sel, input logic m, input logic [127:0] k);
    @(negedge Clk);
    key_mode = m;
    key = k;
    if (sel) start11 = 1'b1;
    else start = 1'b1;
    #1 flush_t = sel ? flush11 : flush;
    @(negedge Clk);
    start = 1'b0;
    start11 = 1'b0;
  endtask

  // Records writes, done and flush over a fixed 40-cycle window; cycle 1 is T+1.
  task automatic capture(input bit sel);
    logic w, d, f, b;
    logic [7:0] a;
    logic [63:0] k;
    cap_n = 0; done_cyc = -1; done_cnt = 0; flush_cnt = 0; busy_mis = 0;
    for (int c = 1; c <= 40; c++) begin
      w = sel ? WE11 : WE;
      d = sel ? done11 : done;
      f = sel ? flush11 : flush;
      b = sel ? busy11 : busy;
      a = sel ? {4'd0, WAddr11} : {3'd0, WAddr};
      k = sel ? KeyIn11 : KeyIn;
      if (w) begin
        if (cap_n < 64) begin
          cap_addr[cap_n] = a;
          cap_dat[cap_n] = k;
          rc_log[cap_n] = dut.rc_q;
        end
        cap_n++;
      end
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (f) flush_cnt++;
      if (w !== b) busy_mis++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", WE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_checks++; if (WAddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", WAddr); end
    n_checks++; if (KeyIn !== 64'd0) begin n_fail++; $display("FAIL reset_keyin: got %h want 0", KeyIn); end
    RstN = 1'b1;
    repeat (2) @(negedge Clk);
    n_checks++; if (WE !== 1'b0 || WE11 !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b/%b want 0/0", WE, WE11); end
  endtask

  task automatic test_128_zero();
    pulse_start(1'b0, 1'b1, '0);
    n_checks++; if (flush_t !== 1'b1) begin n_fail++; $display("FAIL k128_flush_t: got %b want 1", flush_t); end
    capture(1'b0);
    n_checks++; if (cap_n != 26) begin n_fail++; $display("FAIL k128_writes: got %0d want 26", cap_n); end
    for (int i = 0; i < 26; i++) begin
      n_checks++;
      if (cap_addr[i] !== 8'(i)) begin n_fail++; $display("FAIL k128_addr[%0d]: got %0d want %0d", i, cap_addr[i], i); end
    end
    n_checks++; if (cap_dat[0] !== 64'd0) begin n_fail++; $display("FAIL k128_k0: got %h want 0", cap_dat[0]); end
    n_checks++; if (cap_dat[1] !== K1_128) begin n_fail++; $display("FAIL k128_k1: got %h want %h", cap_dat[1], K1_128); end
    n_checks++; if (cap_dat[2] !== K2_128) begin n_fail++; $display("FAIL k128_k2: got %h want %h", cap_dat[2], K2_128); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL k128_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc != 27) begin n_fail++; $display("FAIL k128_done_cyc: got %0d want 27", done_cyc); end
    n_checks++; if (flush_cnt != 0) begin n_fail++; $display("FAIL k128_extra_flush: got %0d want 0", flush_cnt); end
    n_checks++; if (busy_mis != 0) begin n_fail++; $display("FAIL k128_busy: got %0d mismatching cycles want 0", busy_mis); end
  endtask

  task automatic test_rc_sequence();
    for (int i = 0; i < 25; i++) begin
      n_checks++;
      if (rc_log[i] !== rc_exp[i]) begin n_fail++; $display("FAIL rc[%0d]: got %h want %h", i, rc_log[i], rc_exp[i]); end
    end
  endtask

  task automatic test_80_zero();
    pulse_start(1'b0, 1'b0, '0);
    capture(1'b0);
    n_checks++; if (cap_n != 26) begin n_fail++; $display("FAIL k80_writes: got %0d want 26", cap_n); end
    n_checks++; if (cap_dat[0] !== 64'd0) begin n_fail++; $display("FAIL k80_k0: got %h want 0", cap_dat[0]); end
    n_checks++; if (cap_dat[1] !== K1_80) begin n_fail++; $display("FAIL k80_k1: got %h want %h", cap_dat[1], K1_80); end
    n_checks++; if (done_cyc != 27) begin n_fail++; $display("FAIL k80_done_cyc: got %0d want 27", done_cyc); end
  endtask

  task automatic test_key_load();
    pulse_start(1'b0, 1'b1, KEYA);
    capture(1'b0);
    n_checks++; if (cap_dat[0] !== K0A_128) begin n_fail++; $display("FAIL load128_k0: got %h want %h", cap_dat[0], K0A_128); end
    pulse_start(1'b0, 1'b0, KEYA);
    capture(1'b0);
    n_checks++; if (cap_dat[0] !== K0A_80) begin n_fail++; $display("FAIL load80_k0: got %h want %h", cap_dat[0], K0A_80); end
  endtask

  task automatic test_start_held();
    logic f0, we29;
    logic [63:0] k1;
    int writes, dcyc, fcyc, fcnt;
    writes = 0; dcyc = -1; fcyc = -1; fcnt = 0; we29 = 1'b0; k1 = '0;
    @(negedge Clk);
    key_mode = 1'b1;
    key = '0;
    start = 1'b1;
    #1 f0 = flush;
    for (int c = 1; c <= 29; c++) begin
      @(negedge Clk);
      key_mode = ~key_mode;
      key = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (c <= 27 && WE) begin
        writes++;
        if (WAddr == 5'd1) k1 = KeyIn;
      end
      if (done && dcyc < 0) dcyc = c;
      if (c <= 28 && flush) begin fcnt++; fcyc = c; end
      if (c == 29) we29 = WE;
    end
    start = 1'b0;
    repeat (40) @(negedge Clk);
    n_checks++; if (f0 !== 1'b1) begin n_fail++; $display("FAIL held_flush_t: got %b want 1", f0); end
    n_checks++; if (writes != 26) begin n_fail++; $display("FAIL held_writes: got %0d want 26", writes); end
    n_checks++; if (k1 !== K1_128) begin n_fail++; $display("FAIL held_k1: got %h want %h", k1, K1_128); end
    n_checks++; if (dcyc != 27) begin n_fail++; $display("FAIL held_done_cyc: got %0d want 27", dcyc); end
    n_checks++; if (fcnt != 1 || fcyc != 28) begin n_fail++; $display("FAIL held_restart_flush: got %0d at %0d want 1 at 28", fcnt, fcyc); end
    n_checks++; if (we29 !== 1'b1) begin n_fail++; $display("FAIL held_restart_we: got %b want 1", we29); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int stray;
    seen = 1'b0; stray = 0;
    pulse_start(1'b0, 1'b1, KEYA);
    for (int c = 0; c < 40; c++) begin
      if (WE && WAddr == 5'd10) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach_w10: got no write 10 want one"); end
    RstN = 1'b0;
    #1;
    n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b want 0", WE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (WAddr !== 5'd0 || KeyIn !== 64'd0) begin n_fail++; $display("FAIL mid_bus: got %h/%h want 0/0", WAddr, KeyIn); end
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (WE || done) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL mid_after_release: got %0d active cycles want 0", stray); end
    pulse_start(1'b0, 1'b1, '0);
    capture(1'b0);
    n_checks++; if (cap_n != 26 || done_cyc != 27) begin n_fail++; $display("FAIL mid_recover: got %0d writes done %0d want 26/27", cap_n, done_cyc); end
  endtask

  task automatic test_nr11();
    pulse_start(1'b1, 1'b1, '0);
    capture(1'b1);
    n_checks++; if (cap_n != 12) begin n_fail++; $display("FAIL nr11_writes: got %0d want 12", cap_n); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (cap_addr[i] !== 8'(i)) begin n_fail++; $display("FAIL nr11_addr[%0d]: got %0d want %0d", i, cap_addr[i], i); end
    end
    n_checks++; if (cap_dat[1] !== K1_128) begin n_fail++; $display("FAIL nr11_k1: got %h want %h", cap_dat[1], K1_128); end
    n_checks++; if (done_cyc != 13 || done_cnt != 1) begin n_fail++; $display("FAIL nr11_done: got cyc %0d cnt %0d want 13/1", done_cyc, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_128_zero();
    test_rc_sequence();
    test_80_zero();
    test_key_load();
    test_start_held();
    test_reset_mid();
    test_nr11();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
